// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Completion status carried on the response channel.
    typedef enum logic {
        OKAY    = 1'b0,
        TIMEOUT = 1'b1
    } apb_status_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command, response and APB bus signals of the bridge.
// Latency: n/a (wiring only).
// Backpressure: cmd uses valid/ready, rsp uses valid/ready, APB uses pready.
// Modports: master = bridge side, slave = requester/APB-slave environment side.
interface apb_master_bridge_if #(
    parameter int ADDR_W = apb_pkg::ADDR_W,
    parameter int DATA_W = apb_pkg::DATA_W
);
    // command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    // response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_timeout;
    // APB
    logic              psel;
    logic              penable;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_timeout,
               psel, penable, paddr, pwrite, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_timeout,
               psel, penable, paddr, pwrite, pwdata
    );

endinterface

// File: rtl/apb_watchdog.sv
// Saturating ACCESS-cycle counter that flags a stalled APB transfer.
// Latency: expire is combinational from the registered count and en.
// Backpressure: none; counts while en is high, clr restarts it.
// Ports: clk, reset (sync, active-high), clr, en, expire.
module apb_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    // cnt_q = number of ACCESS cycles already completed in this transfer
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires during the TIMEOUT_CYC-th ACCESS cycle, so the abort lands on that edge.
    assign expire = (TIMEOUT_CYC != 0) && en && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Runs one valid/ready command at a time as an APB SETUP+ACCESS transfer and returns a response.
// Latency: accept edge -> rsp_valid after 1 SETUP + N ACCESS edges (3 edges minimum, counting accept).
// Backpressure: cmd_ready low while busy; in RESP cmd_ready follows rsp_ready so commands chain with no bubble.
// Ports: clk, reset (sync, active-high), bus (apb_master_bridge_if.master: cmd_*, rsp_*, APB).
module apb_master_bridge #(
    parameter int ADDR_W      = apb_pkg::ADDR_W,
    parameter int DATA_W      = apb_pkg::DATA_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    apb_master_bridge_if.master   bus
);
    import apb_pkg::*;

    apb_state_e        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    apb_status_e       status_q, status_d;

    // Keeps cmd_ready low for the cycle that reset was sampled, even though state is IDLE.
    logic in_reset_q;
    logic cmd_ready;
    logic accept;
    logic wd_en;
    logic wd_expire;

    assign cmd_ready = !in_reset_q &&
                       ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready));
    assign accept    = cmd_ready && bus.cmd_valid;
    assign wd_en     = (state_q == ACCESS);

    apb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        status_d    = status_q;

        case (state_q)
            IDLE, RESP: begin
                if ((state_q == RESP) && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
                if (accept) begin
                    paddr_d  = bus.cmd_addr;
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_wdata;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A slave completing on the last allowed cycle wins over the watchdog.
                if (bus.pready || wd_expire) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = pwrite_q;
                    state_d     = RESP;
                    if (bus.pready) begin
                        status_d    = OKAY;
                        rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
                    end else begin
                        status_d    = TIMEOUT;
                        rsp_rdata_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            status_q    <= OKAY;
            in_reset_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            status_q    <= status_d;
            in_reset_q  <= 1'b0;
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_write   = rsp_write_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_timeout = (status_q == TIMEOUT);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: APB slave memory with programmable wait states, a
// transaction-level reference (memory array + timing rule) and directed plus random sequences.
module tb_apb_master_bridge;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    apb_master_bridge_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    apb_master_bridge #(
        .ADDR_W      (8),
        .DATA_W      (32),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit        wr;
        bit [7:0]  addr;
        bit [31:0] wdata;
        int        wt;    // pready low cycles before the slave answers
        int        rdly;  // cycles rsp_ready stays low once the response is up
    } txn_t;

    txn_t        q[$];
    longint      accept_t[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_mem [256];
    logic [31:0] slv_mem [256];
    int          slv_wait = 0;
    int          acc_cnt = 0;
    logic        exp_wr;
    logic [31:0] exp_rdata;
    logic        exp_to;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // APB slave: answers on ACCESS cycle number slv_wait (0-based); pready is random noise elsewhere.
    always @(negedge clk) begin
        if (bus.psel && bus.penable) begin
            bus.pready = (acc_cnt == slv_wait);
            bus.prdata = slv_mem[bus.paddr];
            if (bus.pready && bus.pwrite) slv_mem[bus.paddr] = bus.pwdata;
            acc_cnt++;
        end else begin
            acc_cnt    = 0;
            bus.pready = 1'($urandom_range(0, 1));
            bus.prdata = $urandom;
        end
    end

    task automatic add(input bit wr, input bit [7:0] addr, input bit [31:0] wdata,
                       input int wt, input int rdly);
        txn_t t;
        t.wr = wr; t.addr = addr; t.wdata = wdata; t.wt = wt; t.rdly = rdly;
        q.push_back(t);
    endtask

    // Holds rsp_ready low for rdly cycles checking the response is frozen, then raises it.
    task automatic hold_rsp(input int rdly);
        for (int k = 0; k < rdly; k++) begin
            bus.rsp_ready = 1'b0;
            #1;
            chk("hold_cmd_ready", bus.cmd_ready, 0);
            chk("hold_rsp_valid", bus.rsp_valid, 1);
            chk("hold_rsp_write", bus.rsp_write, exp_wr);
            chk("hold_rsp_rdata", bus.rsp_rdata, exp_rdata);
            chk("hold_rsp_timeout", bus.rsp_timeout, exp_to);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("release_cmd_ready", bus.cmd_ready, 1);
    endtask

    task automatic run_seq();
        txn_t t;
        bit   have_prev = 1'b0;
        int   prev_rdly = 0;
        int   n_exp, edges, pen, bad, n;
        bit   to;
        while (q.size() > 0) begin
            t = q.pop_front();
            bus.cmd_valid = 1'b1;
            bus.cmd_write = t.wr;
            bus.cmd_addr  = t.addr;
            bus.cmd_wdata = t.wdata;
            slv_wait      = t.wt;
            if (have_prev) begin
                hold_rsp(prev_rdly);
            end else begin
                n = 0;
                #1;
                while (!bus.cmd_ready && n < 20) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                chk("idle_cmd_ready", bus.cmd_ready, 1);
            end
            @(posedge clk);
            accept_t.push_back($time);
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.rsp_ready = 1'b0;
            bus.cmd_write = 1'($urandom_range(0, 1));
            bus.cmd_addr  = 8'($urandom);
            bus.cmd_wdata = $urandom;

            // reference: transfer outcome from the wait count and the memory image
            to        = (t.wt >= TO);
            n_exp     = to ? TO : t.wt + 1;
            exp_wr    = t.wr;
            exp_to    = to;
            exp_rdata = (to || t.wr) ? 32'h0 : ref_mem[t.addr];
            if (!to && t.wr) ref_mem[t.addr] = t.wdata;

            chk("setup_psel", bus.psel, 1);
            chk("setup_penable", bus.penable, 0);
            chk("setup_rsp_valid", bus.rsp_valid, 0);
            chk("setup_paddr", bus.paddr, t.addr);
            chk("setup_pwrite", bus.pwrite, t.wr);
            if (t.wr) chk("setup_pwdata", bus.pwdata, t.wdata);

            edges = 1; pen = 0; bad = 0;
            while (!bus.rsp_valid && edges < 60) begin
                @(posedge clk);
                edges++;
                @(negedge clk);
                if (!bus.rsp_valid) begin
                    if (bus.penable) pen++;
                    if (bus.psel !== 1'b1 || bus.paddr !== t.addr || bus.pwrite !== t.wr ||
                        (t.wr && bus.pwdata !== t.wdata)) bad++;
                end
            end
            chk("latency_edges", edges, n_exp + 2);
            chk("penable_cycles", pen, n_exp);
            chk("apb_stable", bad, 0);
            chk("rsp_psel_low", bus.psel, 0);
            chk("rsp_penable_low", bus.penable, 0);
            chk("rsp_paddr_kept", bus.paddr, t.addr);
            chk("rsp_write", bus.rsp_write, exp_wr);
            chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
            chk("rsp_timeout", bus.rsp_timeout, exp_to);
            have_prev = 1'b1;
            prev_rdly = t.rdly;
        end
        if (have_prev) begin
            hold_rsp(prev_rdly);
            @(posedge clk);
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            #1;
            chk("drain_rsp_valid", bus.rsp_valid, 0);
            chk("drain_cmd_ready", bus.cmd_ready, 1);
            @(negedge clk);
        end
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'h0;
            slv_mem[i] = 32'h0;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_pwdata", bus.pwdata, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);

        // directed: write, waited read, timeout and recovery, wait boundaries, held response
        add(1, 8'h10, 32'hDEADBEEF, 0, 0);
        add(0, 8'h10, 32'h0, 3, 0);
        add(0, 8'h20, 32'h0, 255, 0);
        add(1, 8'h20, 32'h12345678, 0, 0);
        add(0, 8'h10, 32'h0, TO - 1, 5);
        add(1, 8'h11, 32'hCAFEF00D, TO, 0);
        add(0, 8'h11, 32'h0, 0, 0);
        add(0, 8'h20, 32'h0, 1, 0);
        run_seq();

        // reset during ACCESS of a read
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h10;
        slv_wait      = 10;
        #1;
        chk("rr_cmd_ready", bus.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rr_in_access", bus.penable, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rr_psel", bus.psel, 0);
        chk("rr_penable", bus.penable, 0);
        chk("rr_rsp_valid", bus.rsp_valid, 0);
        chk("rr_cmd_ready", bus.cmd_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rr_release_cmd_ready", bus.cmd_ready, 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.psel) cnt++;
        end
        chk("rr_no_response", cnt, 0);
        add(0, 8'h10, 32'h0, 0, 0);
        run_seq();

        // back-to-back writes: one accept every 3 cycles
        accept_t.delete();
        for (int i = 0; i < 4; i++) add(1, 8'(i), 32'hA0000000 + i, 0, 0);
        run_seq();
        for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(accept_t[i] - accept_t[i-1]), 30);
        for (int i = 0; i < 4; i++) add(0, 8'(i), 32'h0, 0, 0);
        run_seq();

        // random traffic
        for (int i = 0; i < 40; i++) begin
            add(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
                ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 3),
                $urandom_range(0, 2));
        end
        run_seq();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
